// File: rtl/conv_pkg.sv
// conv_pkg: shared widths and window byte placement for the 3x3x3 RGB conv datapath.
package conv_pkg;
    localparam int PIX_W = 8;
    localparam int CH_W  = 9 * PIX_W;
    localparam int WIN_W = 27 * PIX_W;
    localparam int R_LSB = 18 * PIX_W;
    localparam int G_LSB = 9 * PIX_W;
    localparam int B_LSB = 0;

    // MSB of tap k_n inside one channel slice; k_0 sits at the top byte.
    function automatic int k_msb(input int n, input int pix_w);
        return (9 - n) * pix_w - 1;
    endfunction
endpackage

// File: rtl/line_buffer.sv
// line_buffer: one-line pixel store, single address per cycle, read returns the old contents.
module line_buffer #(
    parameter int DEPTH = 16,
    parameter int W     = 24
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  logic [W-1:0]             wr_data,
    output logic [W-1:0]             rd_data
);
    logic [W-1:0] mem [DEPTH];

    assign rd_data = mem[addr];

    always_ff @(posedge clk)
        if (we) mem[addr] <= wr_data;
endmodule

// File: rtl/rgb_window_gen.sv
// rgb_window_gen: turns a raster RGB pixel stream into valid-only 3x3 windows per channel.
module rgb_window_gen #(
    parameter int IMG_W = 16,
    parameter int IMG_H = 16,
    parameter int PIX_W = conv_pkg::PIX_W
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  pix_valid_i,
    output logic                  pix_ready_o,
    input  logic [3*PIX_W-1:0]    pix_data_i,
    output logic                  win_valid_o,
    input  logic                  win_ready_i,
    output logic [27*PIX_W-1:0]   win_data_o,
    output logic                  frame_done_o
);
    import conv_pkg::*;

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam int PX = 3 * PIX_W;
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

    logic [CW-1:0]        col;
    logic [RW-1:0]        row;
    logic [PX-1:0]        lb0_rd, lb1_rd;
    logic [PX-1:0]        sh [3][2];
    logic [PX-1:0]        nw [3][3];
    logic [27*PIX_W-1:0]  win_nxt;
    logic                 acc, emit, last, win_last;

    assign pix_ready_o = !win_valid_o || win_ready_i;
    assign acc         = pix_valid_i && pix_ready_o;
    assign emit        = acc && row >= RW'(2) && col >= CW'(2);
    assign last        = row == ROW_LAST && col == COL_LAST;

    line_buffer #(.DEPTH(IMG_W), .W(PX)) u_lb0 (
        .clk(clk_i), .we(acc), .addr(col), .wr_data(pix_data_i), .rd_data(lb0_rd)
    );

    line_buffer #(.DEPTH(IMG_W), .W(PX)) u_lb1 (
        .clk(clk_i), .we(acc), .addr(col), .wr_data(lb0_rd), .rd_data(lb1_rd)
    );

    // Only the two older columns are stored; the newest column comes straight from the buffers.
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            nw[i][0] = sh[i][0];
            nw[i][1] = sh[i][1];
        end
        nw[0][2] = lb1_rd;
        nw[1][2] = lb0_rd;
        nw[2][2] = pix_data_i;
        win_nxt  = '0;
        for (int ch = 0; ch < 3; ch++)
            for (int n = 0; n < 9; n++)
                win_nxt[(2-ch)*9*PIX_W + k_msb(n, PIX_W) -: PIX_W] = nw[n/3][n%3][(3-ch)*PIX_W-1 -: PIX_W];
    end

    always_ff @(posedge clk_i)
        if (acc)
            for (int i = 0; i < 3; i++) begin
                sh[i][0] <= nw[i][1];
                sh[i][1] <= nw[i][2];
            end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            col <= '0;
            row <= '0;
        end else if (acc) begin
            col <= col == COL_LAST ? '0 : col + 1'b1;
            row <= col != COL_LAST ? row : row == ROW_LAST ? '0 : row + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            win_valid_o  <= 1'b0;
            win_data_o   <= '0;
            win_last     <= 1'b0;
            frame_done_o <= 1'b0;
        end else begin
            frame_done_o <= win_valid_o && win_ready_i && win_last;
            if (emit) begin
                win_valid_o <= 1'b1;
                win_data_o  <= win_nxt;
                win_last    <= last;
            end else if (win_ready_i) begin
                win_valid_o <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_rgb_window_gen.sv
// tb_rgb_window_gen: directed checks of a 4x4 and a 16x16 window generator instance.
module tb_rgb_window_gen;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int vec = 0;
    int errs = 0;

    logic         rst4 = 1'b1, pv4 = 1'b0, wr4 = 1'b0, pr4, wv4, fd4;
    logic [23:0]  pd4 = '0;
    logic [215:0] wd4;
    logic         rst16 = 1'b1, pv16 = 1'b0, wr16 = 1'b0, pr16, wv16, fd16;
    logic [23:0]  pd16 = '0;
    logic [215:0] wd16;

    rgb_window_gen #(.IMG_W(4), .IMG_H(4), .PIX_W(8)) dut4 (
        .clk_i(clk), .rst_i(rst4), .pix_valid_i(pv4), .pix_ready_o(pr4), .pix_data_i(pd4),
        .win_valid_o(wv4), .win_ready_i(wr4), .win_data_o(wd4), .frame_done_o(fd4)
    );

    rgb_window_gen #(.IMG_W(16), .IMG_H(16), .PIX_W(8)) dut16 (
        .clk_i(clk), .rst_i(rst16), .pix_valid_i(pv16), .pix_ready_o(pr16), .pix_data_i(pd16),
        .win_valid_o(wv16), .win_ready_i(wr16), .win_data_o(wd16), .frame_done_o(fd16)
    );

    function automatic logic [215:0] exp4(input int t);
        logic [215:0] w;
        logic [7:0]   p;
        w = '0;
        for (int k = 0; k < 9; k++) begin
            p = 8'(t + (k / 3) * 4 + k % 3);
            w[215-8*k -: 8] = p;
            w[143-8*k -: 8] = p + 8'd64;
            w[71-8*k -: 8]  = p + 8'd128;
        end
        return w;
    endfunction

    function automatic logic [23:0] px16(input int f, input int n);
        return {8'(n), 8'(n * 7 + f * 13), 8'(n ^ (f * 16) ^ 165)};
    endfunction

    function automatic logic [215:0] exp16(input int f, input int r, input int c);
        logic [215:0] w;
        logic [23:0]  p;
        w = '0;
        for (int k = 0; k < 9; k++) begin
            p = px16(f, (r + k / 3) * 16 + c + k % 3);
            w[215-8*k -: 8] = p[23:16];
            w[143-8*k -: 8] = p[15:8];
            w[71-8*k -: 8]  = p[7:0];
        end
        return w;
    endfunction

    task automatic tick4(input bit v, input int n, input bit wr, output bit pa, output bit wa);
        @(negedge clk);
        pv4 = v;
        pd4 = {8'(n), 8'(n + 64), 8'(n + 128)};
        wr4 = wr;
        #1;
        pa = v && pr4;
        wa = wv4 && wr;
    endtask

    task automatic tick16(input bit v, input logic [23:0] d, input bit wr, output bit pa, output bit wa);
        @(negedge clk);
        pv16 = v;
        pd16 = d;
        wr16 = wr;
        #1;
        pa = v && pr16;
        wa = wv16 && wr;
    endtask

    task automatic test_reset;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst4 = 1'b0;
        rst16 = 1'b0;
        #1;
        vec++; if (wv4 !== 1'b0) begin errs++; $display("FAIL rst_valid4 got %b want 0", wv4); end
        vec++; if (wd4 !== '0) begin errs++; $display("FAIL rst_data4 got %h want 0", wd4); end
        vec++; if (fd4 !== 1'b0) begin errs++; $display("FAIL rst_done4 got %b want 0", fd4); end
        vec++; if (pr4 !== 1'b1) begin errs++; $display("FAIL rst_ready4 got %b want 1", pr4); end
        vec++; if (wv16 !== 1'b0) begin errs++; $display("FAIL rst_valid16 got %b want 0", wv16); end
        vec++; if (fd16 !== 1'b0) begin errs++; $display("FAIL rst_done16 got %b want 0", fd16); end
    endtask

    task automatic test_stream;
        int n = 0, first = -1, acc10 = -1, lastacc = -1, fdt = -1, fdc = 0;
        int tl [4] = '{0, 1, 4, 5};
        bit pa, wa;
        logic [215:0] got [$];
        for (int tk = 1; tk <= 24; tk++) begin
            tick4(n < 16, n, 1'b1, pa, wa);
            if (fd4) begin fdc++; fdt = tk; end
            if (wv4 && first < 0) first = tk;
            if (wa) begin got.push_back(wd4); if (got.size() == 4) lastacc = tk; end
            if (pa) begin if (n == 10) acc10 = tk; n++; end
        end
        vec++; if (got.size() != 4) begin errs++; $display("FAIL stream_count got %0d want 4", got.size()); end
        vec++; if (first != acc10 + 1) begin errs++; $display("FAIL stream_latency got %0d want %0d", first, acc10 + 1); end
        vec++; if (fdc != 1) begin errs++; $display("FAIL stream_done_count got %0d want 1", fdc); end
        vec++; if (fdt != lastacc + 1) begin errs++; $display("FAIL stream_done_time got %0d want %0d", fdt, lastacc + 1); end
        if (got.size() == 4) begin
            vec++; if (got[0][215:144] !== 72'h00_01_02_04_05_06_08_09_0A) begin
                errs++; $display("FAIL stream_w0_r got %h want 00010204050608090a", got[0][215:144]); end
            vec++; if (got[3][143:72] !== 72'h45_46_47_49_4A_4B_4D_4E_4F) begin
                errs++; $display("FAIL stream_w3_g got %h want 45464749 4a4b4d4e4f", got[3][143:72]); end
            vec++; if (got[3][71:0] !== 72'h85_86_87_89_8A_8B_8D_8E_8F) begin
                errs++; $display("FAIL stream_w3_b got %h want 85868789 8a8b8d8e8f", got[3][71:0]); end
            for (int i = 0; i < 4; i++) begin
                vec++; if (got[i] !== exp4(tl[i])) begin
                    errs++; $display("FAIL stream_w%0d got %h want %h", i, got[i], exp4(tl[i])); end
            end
        end
    endtask

    task automatic test_backpressure;
        int n = 0, held = 0;
        int tl [4] = '{0, 1, 4, 5};
        bit pa, wa, hold;
        logic [215:0] snap = '0;
        logic [215:0] got [$];
        for (int tk = 1; tk <= 35; tk++) begin
            hold = wv4 && held < 5;
            tick4(n < 16, n, !hold, pa, wa);
            if (hold) begin
                if (held == 0) snap = wd4;
                else begin
                    vec++; if (wd4 !== snap) begin errs++; $display("FAIL bp_stable got %h want %h", wd4, snap); end
                end
                vec++; if (pr4 !== 1'b0) begin errs++; $display("FAIL bp_ready got %b want 0", pr4); end
                held++;
            end
            if (wa) got.push_back(wd4);
            if (pa) n++;
        end
        vec++; if (held != 5) begin errs++; $display("FAIL bp_hold got %0d want 5", held); end
        vec++; if (n != 16) begin errs++; $display("FAIL bp_pixels got %0d want 16", n); end
        vec++; if (got.size() != 4) begin errs++; $display("FAIL bp_count got %0d want 4", got.size()); end
        if (got.size() == 4)
            for (int i = 0; i < 4; i++) begin
                vec++; if (got[i] !== exp4(tl[i])) begin
                    errs++; $display("FAIL bp_w%0d got %h want %h", i, got[i], exp4(tl[i])); end
            end
    endtask

    task automatic test_reset_mid;
        int n = 0;
        int tl [4] = '{0, 1, 4, 5};
        bit pa, wa;
        logic [215:0] got [$];
        for (int tk = 0; tk < 20 && n < 11; tk++) begin
            tick4(1'b1, n, 1'b0, pa, wa);
            if (pa) n++;
        end
        @(negedge clk);
        pv4 = 1'b0;
        #1;
        vec++; if (wv4 !== 1'b1) begin errs++; $display("FAIL mid_held got %b want 1", wv4); end
        rst4 = 1'b1;
        @(negedge clk);
        rst4 = 1'b0;
        #1;
        vec++; if (wv4 !== 1'b0) begin errs++; $display("FAIL mid_valid got %b want 0", wv4); end
        vec++; if (pr4 !== 1'b1) begin errs++; $display("FAIL mid_ready got %b want 1", pr4); end
        n = 0;
        for (int tk = 1; tk <= 22; tk++) begin
            tick4(n < 16, n, 1'b1, pa, wa);
            if (wa) got.push_back(wd4);
            if (pa) n++;
        end
        vec++; if (got.size() != 4) begin errs++; $display("FAIL mid_count got %0d want 4", got.size()); end
        if (got.size() == 4)
            for (int i = 0; i < 4; i++) begin
                vec++; if (got[i] !== exp4(tl[i])) begin
                    errs++; $display("FAIL mid_w%0d got %h want %h", i, got[i], exp4(tl[i])); end
            end
    endtask

    task automatic test_random;
        int pixn = 0, nwin = 0, fdc = 0, tail = 0, tk = 0;
        bit pa, wa, v, wr;
        logic [215:0] q [$];
        while (tail < 4 && tk < 20000) begin
            v  = pixn < 768 && $urandom_range(0, 3) != 0;
            wr = $urandom_range(0, 2) != 0;
            tick16(v, px16(pixn / 256, pixn % 256), wr, pa, wa);
            tk++;
            if (fd16) fdc++;
            if (wa) begin
                vec++;
                if (q.size() == 0) begin errs++; $display("FAIL rnd_extra window %h", wd16); end
                else if (wd16 !== q[0]) begin errs++; $display("FAIL rnd_w%0d got %h want %h", nwin, wd16, q[0]); end
                if (q.size() != 0) void'(q.pop_front());
                nwin++;
            end
            if (pa) begin
                if ((pixn % 256) / 16 >= 2 && pixn % 16 >= 2)
                    q.push_back(exp16(pixn / 256, (pixn % 256) / 16 - 2, pixn % 16 - 2));
                pixn++;
            end
            if (pixn == 768 && q.size() == 0) tail++;
        end
        vec++; if (tail < 4) begin errs++; $display("FAIL rnd_timeout pixels %0d want 768", pixn); end
        vec++; if (nwin != 588) begin errs++; $display("FAIL rnd_count got %0d want 588", nwin); end
        vec++; if (fdc != 3) begin errs++; $display("FAIL rnd_done got %0d want 3", fdc); end
    endtask

    task automatic test_back_to_back;
        int pixn = 0, nwin = 0, fdc = 0;
        bit pa, wa, expv = 1'b0;
        for (int tk = 1; tk <= 262; tk++) begin
            tick16(pixn < 256, px16(5, pixn), 1'b1, pa, wa);
            vec++; if (wv16 !== expv) begin errs++; $display("FAIL b2b_valid tick %0d got %b want %b", tk, wv16, expv); end
            if (pixn < 256) begin
                vec++; if (pr16 !== 1'b1) begin errs++; $display("FAIL b2b_ready tick %0d got %b want 1", tk, pr16); end
            end
            if (fd16) fdc++;
            if (wa) begin
                vec++; if (wd16 !== exp16(5, (pixn - 1) / 16 - 2, (pixn - 1) % 16 - 2)) begin
                    errs++; $display("FAIL b2b_w%0d got %h", nwin, wd16); end
                nwin++;
            end
            expv = pa && pixn / 16 >= 2 && pixn % 16 >= 2;
            if (pa) pixn++;
        end
        vec++; if (nwin != 196) begin errs++; $display("FAIL b2b_count got %0d want 196", nwin); end
        vec++; if (fdc != 1) begin errs++; $display("FAIL b2b_done got %0d want 1", fdc); end
    endtask

    initial begin
        test_reset;
        test_stream;
        test_backpressure;
        test_reset_mid;
        test_random;
        test_back_to_back;
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end
endmodule
